// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the regfile write-port arbiter.
// Optional build macro: REGFILE_ARB_FIXED_PRIO_EN.
package regfile_arb_pkg;
  typedef enum logic {
    CLEAR,
    RUN
  } arb_state_t;

  localparam int REG_COUNT = 32;
  localparam int ZERO_REG  = 0;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority one-hot grant search.
// The fixed-priority build ties ptr_i to zero.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    // upper segment from the pointer first, then wrap to the bottom
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && i >= int'(ptr_i) && req_i[i]) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && i < int'(ptr_i) && req_i[i]) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Regfile write-port arbiter with x1..x31 clear sequencer.
// Define REGFILE_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module regfile_wr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      clear_req,
  output logic                      busy,
  output logic                      write_en,
  output logic [ADDR_W-1:0]         write_ad,
  output logic [DATA_W-1:0]         data_in
);

  localparam int PW = $clog2(NUM_REQ);

  arb_state_t          state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                busy_q;
  logic                we_q;
  logic [ADDR_W-1:0]   wad_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [PW-1:0]       ptr;
  logic [NUM_REQ-1:0]  gnt;
  logic                any;
  logic [ADDR_W-1:0]   gaddr;
  logic [DATA_W-1:0]   gdata;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] gidx;

  assign ptr = ptr_q;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) gidx = PW'(i);
    end
    ptr_d = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  end
`endif

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .PW     (PW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr),
    .gnt_o (gnt)
  );

  assign req_ready = (state_q == RUN && !clear_req) ? gnt : '0;
  assign any       = |req_ready;

  always_comb begin
    gaddr = '0;
    gdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        gaddr = req_addr[i*ADDR_W +: ADDR_W];
        gdata = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : RUN;
      cnt_q   <= ADDR_W'(1);
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      wad_q   <= '0;
      wdata_q <= '0;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        CLEAR: begin
          we_q    <= 1'b1;
          wad_q   <= cnt_q;
          wdata_q <= '0;
          busy_q  <= 1'b1;
          if (cnt_q == ADDR_W'(REG_COUNT - 1)) begin
            state_q <= RUN;
            cnt_q   <= ADDR_W'(1);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          busy_q <= 1'b0;
          if (clear_req) begin
            state_q <= CLEAR;
            cnt_q   <= ADDR_W'(1);
            we_q    <= 1'b0;
          end else begin
            // x0 grants are consumed but never written
            we_q <= any && (gaddr != ADDR_W'(ZERO_REG));
            if (any) begin
              wad_q   <= gaddr;
              wdata_q <= gdata;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
              ptr_q   <= ptr_d;
`endif
            end
          end
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign write_en = we_q;
  assign write_ad = wad_q;
  assign data_in  = wdata_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: behavioural model plus directed checks.
// Optional build macro: REGFILE_ARB_FIXED_PRIO_EN.
module tb_regfile_wr_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam bit CLR_RST = 1'b1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            clear_req = 1'b0;
  logic [N-1:0]    req_ready;
  logic            busy;
  logic            write_en;
  logic [AW-1:0]   write_ad;
  logic [DW-1:0]   data_in;

  int checks = 0;
  int failures = 0;

  regfile_wr_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW),
    .CLEAR_ON_RESET(CLR_RST)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready),
    .clear_req(clear_req), .busy(busy),
    .write_en(write_en), .write_ad(write_ad),
    .data_in(data_in)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  // Behavioural model: clear progress, rr pointer, expected outputs.
  int            m_clr = 0;
  int            m_ptr = 0;
  logic          e_we = 1'b0;
  logic          e_busy = 1'b0;
  logic [AW-1:0] e_ad = '0;
  logic [DW-1:0] e_d = '0;

  always @(negedge clk) begin : model
    logic [N-1:0]  er;
    logic [AW-1:0] ga;
    int            g;
    int            i;
    if (!reset) begin
      m_clr  = CLR_RST ? 1 : 0;
      m_ptr  = 0;
      e_we   = 1'b0;
      e_ad   = '0;
      e_d    = '0;
      e_busy = 1'b0;
    end
    chk("m_we", write_en, e_we);
    chk("m_busy", busy, e_busy);
    if (e_we || !reset) begin
      chk("m_ad", write_ad, e_ad);
      chk("m_data", data_in, e_d);
    end
    er = '0;
    g  = -1;
    if (m_clr == 0 && !clear_req) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("m_ready", req_ready, er);
    if (reset) begin
      if (m_clr != 0) begin
        e_we   = 1'b1;
        e_ad   = AW'(m_clr);
        e_d    = '0;
        e_busy = 1'b1;
        m_clr  = (m_clr == 31) ? 0 : m_clr + 1;
      end else begin
        e_busy = 1'b0;
        e_we   = 1'b0;
        if (clear_req) begin
          m_clr = 1;
        end else if (g >= 0) begin
          ga = req_addr[g*AW +: AW];
          e_we = (ga != 0);
          if (ga != 0) begin
            e_ad = ga;
            e_d  = req_data[g*DW +: DW];
          end
`ifndef REGFILE_ARB_FIXED_PRIO_EN
          m_ptr = (g + 1) % N;
`endif
        end
      end
    end
  end

  task automatic setreq(int i, bit v, logic [AW-1:0] a,
                        logic [DW-1:0] d);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_run(string nm);
    int n = 0;
    int bad = 0;
    int cyc = 0;
    while (!busy && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    while (busy && cyc < 100) begin
      if (!write_en || write_ad !== AW'(n + 1)
          || data_in !== '0) bad++;
      n++;
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_len"}, n, 31);
    chk({nm, "_seq"}, bad, 0);
    chk({nm, "_idle_we"}, write_en, 0);
  endtask

  initial begin : stim
    logic [N-1:0] ex;
    int cyc;
    #12;
    chk("rst_we", write_en, 0);
    chk("rst_ad", write_ad, 0);
    chk("rst_data", data_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    drive_edge();
    reset = 1'b1;
    clear_run("boot");

    drive_edge();
    setreq(0, 1, 5, 32'hA);
    setreq(1, 1, 6, 32'hB);
    setreq(2, 1, 7, 32'hC);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      ex = '0;
      ex[k % 3] = 1'b1;
      chk("rr_ready", req_ready, ex);
      if (k > 0) begin
        chk("rr_we", write_en, 1);
        chk("rr_ad", write_ad, 5 + ((k - 1) % 3));
      end
    end
    drive_edge();
    req_valid = '0;
    @(negedge clk);
    chk("rr_last_ad", write_ad, 7);
    chk("rr_last_data", data_in, 32'hC);

    drive_edge();
    setreq(1, 1, 0, 32'hDEADBEEF);
    @(negedge clk);
    chk("x0_ready", req_ready, 3'b010);
    drive_edge();
    setreq(1, 0, 0, 0);
    @(negedge clk);
    chk("x0_we", write_en, 0);
    drive_edge();
    setreq(0, 1, 3, 32'h33);
    setreq(2, 1, 4, 32'h44);
    @(negedge clk);
    chk("x0_next", req_ready, 3'b100);
    drive_edge();
    setreq(2, 0, 0, 0);
    @(negedge clk);
    chk("x0_r0", req_ready, 3'b001);
    chk("x0_ad4", write_ad, 4);
    drive_edge();
    setreq(0, 0, 0, 0);
    @(negedge clk);
    chk("x0_ad3", write_ad, 3);
    chk("x0_d3", data_in, 32'h33);

    drive_edge();
    setreq(0, 1, 9, 32'h99);
    clear_req = 1'b1;
    @(negedge clk);
    chk("clr_ready", req_ready, 0);
    drive_edge();
    clear_req = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (req_ready == 0 && cyc < 100);
    chk("clr_cycles", cyc, 32);
    chk("clr_first", req_ready, 3'b001);
    chk("clr_lastad", write_ad, 31);
    drive_edge();
    setreq(0, 0, 0, 0);
    @(negedge clk);
    chk("clr_we", write_en, 1);
    chk("clr_ad", write_ad, 9);
    chk("clr_busy", busy, 0);

    drive_edge();
    clear_req = 1'b1;
    drive_edge();
    clear_req = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(busy && write_ad == 10) && cyc < 50);
    chk("mid_at10", write_ad, 10);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_we", write_en, 0);
    chk("mid_ad", write_ad, 0);
    chk("mid_busy", busy, 0);
    chk("mid_data", data_in, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    clear_run("rst2");

    drive_edge();
    setreq(0, 1, 1, 32'h11);
    setreq(2, 1, 2, 32'h22);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
`ifdef REGFILE_ARB_FIXED_PRIO_EN
      ex = 3'b001;
`else
      ex = (k % 2 == 1) ? 3'b100 : 3'b001;
`endif
      chk("pair_ready", req_ready, ex);
    end
    drive_edge();
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin : watchdog
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $fatal(1);
  end

endmodule
